// File: rtl/seq_sub80.sv
// Multi-cycle subtractor: Diff = A - B - Bin, one CHUNK-bit slice per clock,
// LSB slice first, with the inter-slice borrow held as an inverted carry.
module seq_sub80 #(
    parameter int WIDTH = 80,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_sl, b_sl, s;
    logic             c;
    logic             last;

    // A - B - Bin == A + ~B + ~Bin, so the running carry starts at ~Bin
    always_comb begin
        a_sl   = a_q[idx*CHUNK +: CHUNK];
        b_sl   = b_q[idx*CHUNK +: CHUNK];
        {c, s} = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, carry};
        last   = (idx == IW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= ~Bin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    Diff[idx*CHUNK +: CHUNK] <= s;
                    carry <= c;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        Bout <= ~c;
                        // s[CHUNK-1] is the final sign bit of the difference
                        Ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
